// File: rtl/elevator_shaft_pkg.sv
// Shared encodings for the shaft plant and the movement controller:
// motor command codes, door FSM states and fault bit positions.
package elevator_shaft_pkg;

   localparam logic [1:0] MOTOR_IDLE    = 2'b00;
   localparam logic [1:0] MOTOR_ILLEGAL = 2'b01;
   localparam logic [1:0] MOTOR_UP      = 2'b10;
   localparam logic [1:0] MOTOR_DOWN    = 2'b11;

   typedef enum logic [1:0] {
      DOOR_CLOSED,
      DOOR_OPENING,
      DOOR_OPEN,
      DOOR_CLOSING
   } door_state_e;

   localparam int FLT_INTERLOCK  = 0;
   localparam int FLT_OVERTRAVEL = 1;
   localparam int FLT_ILLEGAL    = 2;

   // One-hot floor sensor for a car position; zero between floors.
   function automatic logic [3:1] floor_onehot(input int unsigned p, input int unsigned travel);
      if (p == 0)             return 3'b001;
      else if (p == travel)   return 3'b010;
      else if (p == 2*travel) return 3'b100;
      else                    return 3'b000;
   endfunction

endpackage

// File: rtl/elevator_shaft_door_timer.sv
// Cab door model: CLOSED/OPENING/OPEN/CLOSING with a stroke timer of
// DOOR_TICKS cycles in each moving phase.
module elevator_shaft_door_timer
   import elevator_shaft_pkg::*;
#(
   parameter int DOOR_TICKS = 4
) (
   input  logic clk,
   input  logic RST,
   input  logic aligned,
   input  logic request,
   input  logic motor_idle,
   output logic door_closed,
   output logic door_open
);

   localparam int CW = $clog2(DOOR_TICKS + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DOOR_TICKS);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   door_state_e   state, state_next;
   logic [CW-1:0] cnt, cnt_next;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; the combinational block below uses blocking ones.
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state <= DOOR_CLOSED;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // NOTE: every output of this block is defaulted first so no path leaves a
   // variable unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      unique case (state)
         DOOR_CLOSED: begin
            if (aligned && request && motor_idle) begin
               state_next = DOOR_OPENING;
               cnt_next   = CNT_LOAD;
            end
         end
         DOOR_OPENING: begin
            if (cnt == CNT_ONE) state_next = DOOR_OPEN;
            else                cnt_next   = cnt - CNT_ONE;
         end
         DOOR_OPEN: begin
            if (!request) begin
               state_next = DOOR_CLOSING;
               cnt_next   = CNT_LOAD;
            end
         end
         DOOR_CLOSING: begin
            // A renewed request reverses the stroke, even on the final tick.
            if (request) begin
               state_next = DOOR_OPENING;
               cnt_next   = CNT_LOAD;
            end else if (cnt == CNT_ONE) begin
               state_next = DOOR_CLOSED;
            end else begin
               cnt_next = cnt - CNT_ONE;
            end
         end
         default: state_next = DOOR_CLOSED;
      endcase
   end

   assign door_closed = (state == DOOR_CLOSED);
   assign door_open   = (state == DOOR_OPEN);

endmodule

// File: rtl/elevator_shaft.sv
// Three-floor shaft plant: car position counter, floor sensors, cab door
// and sticky fault flags, answering the movement controller's commands.
module elevator_shaft
   import elevator_shaft_pkg::*;
#(
   parameter int TRAVEL_TICKS = 8,
   parameter int DOOR_TICKS   = 4,
   parameter int INIT_FLOOR   = 1,
   localparam int W           = $clog2(2*TRAVEL_TICKS + 1)
) (
   input  logic         clk,
   input  logic         RST,
   input  logic [1:0]   motorIn,
   input  logic [3:1]   doorIn,
   output logic [3:1]   loc,
   output logic [3:1]   doorOpen,
   output logic [W-1:0] pos,
   output logic [2:0]   fault
);

   localparam logic [W-1:0] POS_MAX  = W'(2*TRAVEL_TICKS);
   localparam logic [W-1:0] POS_INIT = W'((INIT_FLOOR-1)*TRAVEL_TICKS);
   localparam logic [W-1:0] POS_ONE  = W'(1);

   logic         door_closed, door_open;
   logic         aligned, request, motor_idle;
   logic [W-1:0] pos_next;
   logic [2:0]   fault_set;

   // loc is exactly the aligned-floor one-hot of the current pos.
   assign aligned    = |loc;
   assign request    = |(doorIn & loc);
   assign motor_idle = (motorIn == MOTOR_IDLE);

   elevator_shaft_door_timer #(
      .DOOR_TICKS (DOOR_TICKS)
   ) u_door (
      .clk         (clk),
      .RST         (RST),
      .aligned     (aligned),
      .request     (request),
      .motor_idle  (motor_idle),
      .door_closed (door_closed),
      .door_open   (door_open)
   );

   always_comb begin
      pos_next  = pos;
      fault_set = '0;
      if (motorIn == MOTOR_ILLEGAL) fault_set[FLT_ILLEGAL] = 1'b1;
      if (!motor_idle && !door_closed) begin
         fault_set[FLT_INTERLOCK] = 1'b1;
      end else if (motorIn == MOTOR_UP) begin
         if (pos == POS_MAX) fault_set[FLT_OVERTRAVEL] = 1'b1;
         else                pos_next = pos + POS_ONE;
      end else if (motorIn == MOTOR_DOWN) begin
         if (pos == '0) fault_set[FLT_OVERTRAVEL] = 1'b1;
         else           pos_next = pos - POS_ONE;
      end
   end

   // NOTE: all plant state, including the sticky faults, is cleared by reset
   // so a mid-stroke or mid-travel reset lands in a known configuration.
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         pos   <= POS_INIT;
         loc   <= floor_onehot(32'(POS_INIT), TRAVEL_TICKS);
         fault <= '0;
      end else begin
         pos   <= pos_next;
         loc   <= floor_onehot(32'(pos_next), TRAVEL_TICKS);
         fault <= fault | fault_set;
      end
   end

   assign doorOpen = door_open ? loc : 3'b000;

endmodule

// File: tb/tb_elevator_shaft.sv
// Self-checking bench for elevator_shaft: directed scenarios plus random
// motor/door traffic against a timestamp-based behavioural model.
module tb_elevator_shaft;

   localparam int TT = 8;
   localparam int DT = 4;
   localparam int IF = 1;
   localparam int W  = $clog2(2*TT + 1);

   localparam logic [1:0] M_IDLE = 2'b00;
   localparam logic [1:0] M_ILL  = 2'b01;
   localparam logic [1:0] M_UP   = 2'b10;
   localparam logic [1:0] M_DN   = 2'b11;

   logic         clk = 1'b0;
   logic         RST;
   logic [1:0]   motorIn;
   logic [3:1]   doorIn;
   logic [3:1]   loc;
   logic [3:1]   doorOpen;
   logic [W-1:0] pos;
   logic [2:0]   fault;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: position as an integer, door as a named phase with the edge index
   // at which that phase was entered.
   int         m_pos;
   string      m_phase;
   int         m_since;
   int         m_edge;
   logic [2:0] m_fault;

   elevator_shaft dut (
      .clk      (clk),
      .RST      (RST),
      .motorIn  (motorIn),
      .doorIn   (doorIn),
      .loc      (loc),
      .doorOpen (doorOpen),
      .pos      (pos),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int floor_of(input int p);
      if (p == 0)    return 1;
      if (p == TT)   return 2;
      if (p == 2*TT) return 3;
      return 0;
   endfunction

   function automatic logic [3:1] sensor(input int p);
      logic [3:1] v;
      v = 3'b000;
      if (floor_of(p) != 0) v[floor_of(p)] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      m_pos   = (IF - 1) * TT;
      m_phase = "closed";
      m_since = 0;
      m_edge  = 0;
      m_fault = 3'b000;
   endtask

   task automatic model_step(input logic [1:0] m, input logic [3:1] d);
      int  fl;
      bit  req;
      bit  shut;
      m_edge++;
      fl   = floor_of(m_pos);
      req  = (fl != 0) && d[fl];
      shut = (m_phase == "closed");
      if (m == M_ILL) m_fault[2] = 1'b1;
      if (m != M_IDLE && !shut) m_fault[0] = 1'b1;
      else if (m == M_UP)  begin if (m_pos == 2*TT) m_fault[1] = 1'b1; else m_pos++; end
      else if (m == M_DN)  begin if (m_pos == 0)    m_fault[1] = 1'b1; else m_pos--; end
      if (m_phase == "closed") begin
         if (req && m == M_IDLE) begin m_phase = "opening"; m_since = m_edge; end
      end else if (m_phase == "opening") begin
         if (m_edge - m_since == DT) begin m_phase = "open"; m_since = m_edge; end
      end else if (m_phase == "open") begin
         if (!req) begin m_phase = "closing"; m_since = m_edge; end
      end else begin
         if (req) begin m_phase = "opening"; m_since = m_edge; end
         else if (m_edge - m_since == DT) begin m_phase = "closed"; m_since = m_edge; end
      end
   endtask

   task automatic compare_model();
      check("pos", 32'(pos), 32'(m_pos));
      check("loc", 32'(loc), 32'(sensor(m_pos)));
      check("doorOpen", 32'(doorOpen), (m_phase == "open") ? 32'(sensor(m_pos)) : 32'd0);
      check("fault", 32'(fault), 32'(m_fault));
   endtask

   // Called at a falling edge: drive, let one rising edge pass, compare.
   task automatic cycle(input logic [1:0] m, input logic [3:1] d);
      motorIn = m;
      doorIn  = d;
      @(posedge clk);
      model_step(m, d);
      @(negedge clk);
      compare_model();
   endtask

   // Asynchronous reset asserted away from any clock edge.
   task automatic do_reset(input string tag);
      motorIn = M_IDLE;
      doorIn  = 3'b000;
      #2 RST = 1'b0;
      #1;
      model_reset();
      check({tag, "_pos"},      32'(pos),      32'd0);
      check({tag, "_loc"},      32'(loc),      32'b001);
      check({tag, "_doorOpen"}, 32'(doorOpen), 32'd0);
      check({tag, "_fault"},    32'(fault),    32'd0);
      @(negedge clk);
      RST = 1'b1;
   endtask

   initial begin
      logic [1:0] rm;
      logic [3:1] rd;
      int         run;
      int         r;

      RST     = 1'b1;
      motorIn = M_IDLE;
      doorIn  = 3'b000;
      model_reset();
      @(negedge clk);
      do_reset("rst0");

      // Full up run floor 1 -> floor 3, then overtravel.
      cycle(M_UP, 3'b000);
      check("leave_f1_loc", 32'(loc), 32'd0);
      repeat (TT - 1) cycle(M_UP, 3'b000);
      check("f2_pos", 32'(pos), 32'd8);
      check("f2_loc", 32'(loc), 32'b010);
      repeat (TT) cycle(M_UP, 3'b000);
      check("f3_pos", 32'(pos), 32'd16);
      check("f3_loc", 32'(loc), 32'b100);
      cycle(M_UP, 3'b000);
      check("ovt_fault", 32'(fault), 32'b010);
      check("ovt_pos", 32'(pos), 32'd16);

      // Back to floor 2, open and close the door.
      repeat (TT) cycle(M_DN, 3'b000);
      repeat (DT) cycle(M_IDLE, 3'b010);
      check("door_not_yet", 32'(doorOpen), 32'd0);
      cycle(M_IDLE, 3'b010);
      check("door_open", 32'(doorOpen), 32'b010);
      cycle(M_IDLE, 3'b000);
      check("door_drop", 32'(doorOpen), 32'd0);
      repeat (DT) cycle(M_IDLE, 3'b000);
      cycle(M_UP, 3'b000);
      check("closed_move_pos", 32'(pos), 32'd9);
      check("closed_move_fault", 32'(fault), 32'b010);

      // Interlock with the door open at floor 2.
      do_reset("rst1");
      repeat (TT) cycle(M_UP, 3'b000);
      repeat (DT + 1) cycle(M_IDLE, 3'b010);
      cycle(M_UP, 3'b010);
      check("ilk_pos", 32'(pos), 32'd8);
      check("ilk_fault", 32'(fault), 32'b001);
      check("ilk_door", 32'(doorOpen), 32'b010);
      repeat (DT + 1) cycle(M_IDLE, 3'b000);

      // Reversal and illegal code.
      do_reset("rst2");
      repeat (3) cycle(M_UP, 3'b000);
      repeat (3) cycle(M_DN, 3'b000);
      check("rev_pos", 32'(pos), 32'd0);
      check("rev_loc", 32'(loc), 32'b001);
      check("rev_fault", 32'(fault), 32'd0);
      cycle(M_ILL, 3'b000);
      check("ill_fault", 32'(fault), 32'b100);
      check("ill_pos", 32'(pos), 32'd0);

      // Reset mid-travel, mid-stroke and with the door fully open.
      repeat (5) cycle(M_UP, 3'b000);
      check("mid_pos", 32'(pos), 32'd5);
      do_reset("rst_travel");
      repeat (2) cycle(M_IDLE, 3'b001);
      do_reset("rst_stroke");
      cycle(M_UP, 3'b000);
      check("stroke_snap_pos", 32'(pos), 32'd1);
      do_reset("rst3");
      repeat (DT + 1) cycle(M_IDLE, 3'b001);
      check("f1_open", 32'(doorOpen), 32'b001);
      do_reset("rst_open");

      // Random traffic in blocks, each from a fresh reset.
      for (int blk = 0; blk < 4; blk++) begin
         if (blk != 0) do_reset("rst_rand");
         run = 0;
         rm  = M_IDLE;
         rd  = 3'b000;
         for (int i = 0; i < 150; i++) begin
            if (run == 0) begin
               r = $urandom_range(0, 19);
               if (r < 8)       rm = M_IDLE;
               else if (r < 13) rm = M_UP;
               else if (r < 18) rm = M_DN;
               else             rm = M_ILL;
               rd  = 3'($urandom_range(0, 7));
               run = $urandom_range(1, 12);
            end
            run--;
            cycle(rm, rd);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
